// File: rtl/vq_pkg.sv
// Shared types and default sizes for the VQ decompressor slice.
package vq_pkg;

   localparam int CB_SIZE = 64;
   localparam int IDX_W   = 6;
   localparam int DATA_W  = 24;

   typedef enum logic [1:0] {
      LOAD,
      DECODE,
      DRAIN,
      FINISH
   } vq_state_e;

   // Pixel as stored in RAM: {B,G,R}
   typedef logic [23:0] rgb_t;

endpackage

// File: rtl/vq_codebook_rf.sv
// Codebook register file: one synchronous write port, one combinational read port.
module vq_codebook_rf
   import vq_pkg::*;
#(
   parameter int CB_SIZE = vq_pkg::CB_SIZE,
   parameter int IDX_W   = vq_pkg::IDX_W,
   parameter int DATA_W  = vq_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [CB_SIZE];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/vq_decompress.sv
// VQ decompressor: loads the codebook from RAM1, then maps each tag to an RGB pixel in RAM2.
module vq_decompress
   import vq_pkg::*;
#(
   parameter int CB_SIZE  = vq_pkg::CB_SIZE,
   parameter int IDX_W    = vq_pkg::IDX_W,
   parameter int NUM_PIX  = 4096,
   parameter int TAG_BASE = 64,
   parameter int OUT_BASE = 0,
   parameter int ADDR_W   = 20,
   parameter int DATA_W   = vq_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] RAM1_Q,
   output logic [ADDR_W-1:0] RAM1_A,
   output logic              RAM1_OE,
   output logic              RAM1_WE,
   output logic [DATA_W-1:0] RAM1_D,
   output logic [ADDR_W-1:0] RAM2_A,
   output logic [DATA_W-1:0] RAM2_D,
   output logic              RAM2_WE,
   output logic              RAM2_OE,
   output logic              tag_err,
   output logic              done
);

   localparam int CNT_W = $clog2(NUM_PIX + 1);

   vq_state_e          state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [ADDR_W-1:0]  addr_n;
   logic               ld_n, tg_n;

   logic               ld_vld_p0, ld_vld_p1;
   logic [IDX_W-1:0]   ld_idx_p0, ld_idx_p1;
   logic               tag_vld_p0, tag_vld_p1;
   logic [CNT_W-1:0]   pix_p0;
   logic               tag_err_q;
   logic               tag_bad;
   logic [DATA_W-1:0]  rf_rdata;

   assign RAM1_WE = 1'b0;
   assign RAM1_D  = '0;
   assign RAM2_OE = 1'b0;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      addr_n  = '0;
      ld_n    = 1'b0;
      tg_n    = 1'b0;
      unique case (state)
         LOAD: begin
            ld_n   = 1'b1;
            addr_n = ADDR_W'(cnt);
            if (cnt == CNT_W'(CB_SIZE - 1)) begin
               state_n = DECODE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DECODE: begin
            tg_n   = 1'b1;
            addr_n = ADDR_W'(TAG_BASE) + ADDR_W'(cnt);
            if (cnt == CNT_W'(NUM_PIX - 1)) begin
               state_n = DRAIN;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DRAIN:  state_n = FINISH;
         FINISH: state_n = FINISH;
      endcase
   end

   // Issue stage (p0): address on RAM1; write stage (p1): RAM1_Q is valid
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= LOAD;
         cnt        <= '0;
         RAM1_OE    <= 1'b0;
         RAM1_A     <= '0;
         RAM2_A     <= '0;
         ld_vld_p0  <= 1'b0;
         ld_vld_p1  <= 1'b0;
         tag_vld_p0 <= 1'b0;
         tag_vld_p1 <= 1'b0;
         tag_err_q  <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         RAM1_OE    <= ld_n | tg_n;
         RAM1_A     <= addr_n;
         RAM2_A     <= tag_vld_p0 ? ADDR_W'(OUT_BASE) + ADDR_W'(pix_p0) : '0;
         ld_vld_p0  <= ld_n;
         ld_vld_p1  <= ld_vld_p0;
         tag_vld_p0 <= tg_n;
         tag_vld_p1 <= tag_vld_p0;
         tag_err_q  <= tag_err_q | tag_bad;
         done       <= (state == FINISH);
      end
   end

   always_ff @(posedge clk) begin
      ld_idx_p0 <= cnt[IDX_W-1:0];
      ld_idx_p1 <= ld_idx_p0;
      pix_p0    <= cnt;
   end

   assign tag_bad = tag_vld_p1 && (RAM1_Q[7:IDX_W] != '0);
   assign tag_err = tag_err_q | tag_bad;
   assign RAM2_WE = tag_vld_p1;
   assign RAM2_D  = tag_vld_p1 ? rf_rdata : '0;

   vq_codebook_rf #(
      .CB_SIZE (CB_SIZE),
      .IDX_W   (IDX_W),
      .DATA_W  (DATA_W)
   ) u_rf (
      .clk   (clk),
      .we    (ld_vld_p1),
      .waddr (ld_idx_p1),
      .wdata (RAM1_Q),
      .raddr (RAM1_Q[IDX_W-1:0]),
      .rdata (rf_rdata)
   );

endmodule
